// File: rtl/serial_capture_16bits.sv
// Serial-to-parallel capture of 16-bit words with single-entry output hold and sticky overrun.
// Optional match detector enabled by defining CAPTURE_MATCH_EN.
module serial_capture_16bits #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        shift_in,
  input  logic        sample,
  input  logic        align,
  input  logic        word_ack,
`ifdef CAPTURE_MATCH_EN
  input  logic [15:0] match_word,
  output logic        match,
`endif
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        overrun,
  output logic [3:0]  bit_count
);

  // Output handshake: a word transfers on any rising edge where word_valid=1
  // and word_ack=1; word_ack with word_valid=0 is ignored. A word completing on
  // a transfer edge replaces the departing one, so word_valid stays high.
  logic [15:0] asm_q;
  logic [15:0] assembled;
  logic        strobe;
  logic        complete;
  logic        accept;

  assign assembled = LSB_FIRST ? {shift_in, asm_q[15:1]} : {asm_q[14:0], shift_in};
  assign strobe    = sample & ~align;
  assign complete  = strobe & (bit_count == 4'd15);
  assign accept    = word_ack & word_valid;

  // Assembly register and bit counter; align discards any partial word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      asm_q     <= '0;
      bit_count <= '0;
    end else if (align) begin
      asm_q     <= '0;
      bit_count <= '0;
    end else if (sample) begin
      asm_q     <= complete ? 16'h0000 : assembled;
      bit_count <= bit_count + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete) begin
      if (!word_valid || accept) begin
        word_out   <= assembled;
        word_valid <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (accept) begin
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

`ifdef CAPTURE_MATCH_EN
  // Compares the assembled word, so a word dropped by overrun still matches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= complete && (assembled == match_word);
    end
  end
`endif

endmodule

// File: tb/tb_serial_capture_16bits.sv
// Bench for serial_capture_16bits: MSB-first and LSB-first instances share one stream;
// a bit-list reference model feeds a per-cycle expected queue checked by a monitor.
module tb_serial_capture_16bits;
  localparam int W = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        shift_in = 1'b0;
  logic        sample = 1'b0;
  logic        align = 1'b0;
  logic        word_ack = 1'b0;
  logic [15:0] match_word = 16'hF0F0;

  logic [15:0] wo_m, wo_l;
  logic        wv_m, wv_l, ov_m, ov_l;
  logic [3:0]  bc_m, bc_l;
`ifdef CAPTURE_MATCH_EN
  logic        mt_m, mt_l;
`endif

  serial_capture_16bits #(.LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .reset(reset), .shift_in(shift_in), .sample(sample),
    .align(align), .word_ack(word_ack),
`ifdef CAPTURE_MATCH_EN
    .match_word(match_word), .match(mt_m),
`endif
    .word_out(wo_m), .word_valid(wv_m), .overrun(ov_m), .bit_count(bc_m)
  );

  serial_capture_16bits #(.LSB_FIRST(1'b1)) dut_lsb (
    .clock(clock), .reset(reset), .shift_in(shift_in), .sample(sample),
    .align(align), .word_ack(word_ack),
`ifdef CAPTURE_MATCH_EN
    .match_word(match_word), .match(mt_l),
`endif
    .word_out(wo_l), .word_valid(wv_l), .overrun(ov_l), .bit_count(bc_l)
  );

  always #5 clock = ~clock;

  // Reference model: the partial word is just the list of bits received so far.
  bit          bits_q[$];
  logic [15:0] m_word_m = 16'h0000;
  logic [15:0] m_word_l = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;

  // Expected snapshot after each edge: {word_msb, word_lsb, valid, overrun, bit_count, match_msb, match_lsb}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic sh, input logic smp, input logic aln, input logic ack);
    logic        accepted, complete, mm, ml;
    logic [15:0] wm, wl;
    accepted = 1'b0; complete = 1'b0; mm = 1'b0; ml = 1'b0; wm = '0; wl = '0;
    if (reset) begin
      bits_q.delete();
      m_word_m = '0; m_word_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      accepted = ack && m_valid;
      if (aln) begin
        bits_q.delete();
      end else if (smp) begin
        bits_q.push_back(sh);
        if (bits_q.size() == 16) begin
          for (int i = 0; i < 16; i++) begin
            wm[15-i] = bits_q[i];
            wl[i]    = bits_q[i];
          end
          complete = 1'b1;
          bits_q.delete();
          mm = (wm == match_word);
          ml = (wl == match_word);
        end
      end
      if (complete) begin
        if (!m_valid || accepted) begin
          m_word_m = wm; m_word_l = wl; m_valid = 1'b1; m_ovr = 1'b0;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (accepted) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end
    end
    exp_q.push_back({m_word_m, m_word_l, m_valid, m_ovr, 4'(bits_q.size()), mm, ml});
  endtask

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic step(input logic sh, input logic smp, input logic aln, input logic ack);
    shift_in = sh; sample = smp; align = aln; word_ack = ack;
    model_edge(sh, smp, aln, ack);
    @(negedge clock);
  endtask

  task automatic send_word(input logic [15:0] w, input logic ack_last);
    for (int i = 15; i >= 0; i--) step(w[i], 1'b1, 1'b0, ack_last && (i == 0));
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
  endtask

  // Reset is applied between edges; outputs must clear without a clock.
  task automatic async_reset(input int hold);
    reset = 1'b1;
    #1;
    chk("async_word_msb", wo_m, 16'h0000);
    chk("async_word_lsb", wo_l, 16'h0000);
    chk("async_valid", {15'b0, wv_m | wv_l}, 16'h0000);
    chk("async_overrun", {15'b0, ov_m | ov_l}, 16'h0000);
    chk("async_bit_count", {8'b0, bc_m, bc_l}, 16'h0000);
    for (int i = 0; i < hold; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("word_msb", wo_m, e[39:24]);
      chk("word_lsb", wo_l, e[23:8]);
      chk("valid_msb", {15'b0, wv_m}, {15'b0, e[7]});
      chk("valid_lsb", {15'b0, wv_l}, {15'b0, e[7]});
      chk("overrun_msb", {15'b0, ov_m}, {15'b0, e[6]});
      chk("overrun_lsb", {15'b0, ov_l}, {15'b0, e[6]});
      chk("bit_count_msb", {12'b0, bc_m}, {12'b0, e[5:2]});
      chk("bit_count_lsb", {12'b0, bc_l}, {12'b0, e[5:2]});
`ifdef CAPTURE_MATCH_EN
      chk("match_msb", {15'b0, mt_m}, {15'b0, e[1]});
      chk("match_lsb", {15'b0, mt_l}, {15'b0, e[0]});
`endif
    end
  end

  initial begin
    @(negedge clock);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // F0F0 stream: MSB instance expects F0F0, LSB instance expects 0F0F; match on F0F0.
    send_word(16'hF0F0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back without ack overruns; ack clears.
    send_word(16'hA5A5, 1'b0);
    send_word(16'h1234, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Ack on the completion edge of the second word.
    send_word(16'hA5A5, 1'b0);
    send_word(16'h1234, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Align mid-word with a concurrent strobe, then a clean word.
    send_bits(7);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_word(16'hBEEF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Reset mid-word, then a full word after release.
    send_bits(9);
    async_reset(2);
    send_word(16'hC3A1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Match only on the first of two words.
    match_word = 16'hF0F0;
    send_word(16'hF0F0, 1'b0);
    send_word(16'hF0F1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional align, ack and matching words.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        match_word = ($urandom_range(0, 1) == 1) ? 16'(($urandom)) : 16'hF0F0;
        send_word(match_word, 1'(($urandom_range(0, 1))));
      end
      if (n == 1500) async_reset(1);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
